// File: rtl/arch_map_table_pkg.sv
// Shared widths and types for the retire-side architectural map table.
// Purely declarative: no latency, no flow control.
package arch_map_table_pkg;
  localparam int SIZE_LOGICAL      = 32;
  localparam int SIZE_LOGICAL_LOG  = 5;
  localparam int SIZE_PHYSICAL_LOG = 7;
  localparam int COMMIT_WIDTH      = 4;
  localparam int NUM_GROUPS        = SIZE_LOGICAL / COMMIT_WIDTH;
  localparam int GROUP_W           = SIZE_LOGICAL_LOG - 2;

  typedef logic [SIZE_LOGICAL_LOG-1:0]  log_t;
  typedef logic [SIZE_PHYSICAL_LOG-1:0] phys_t;
  typedef logic [GROUP_W-1:0]           group_t;

  typedef struct packed {
    logic  valid;
    log_t  log_dest;
    phys_t phy_dest;
  } commit_slot_t;
endpackage

// File: rtl/arch_map_table_if.sv
// Retire/free-list/recovery bundle between the retire stage and the AMT.
// Master drives commits and the flush pulse; slave returns freed tags and the walk.
interface arch_map_table_if;
  import arch_map_table_pkg::*;

  commit_slot_t [COMMIT_WIDTH-1:0] commit;
  logic                            recover_flag;
  logic                            commit_ready;
  logic [COMMIT_WIDTH-1:0]         freed_valid;
  phys_t [COMMIT_WIDTH-1:0]        freed_reg;
  logic                            recover_busy;
  logic                            recover_valid;
  group_t                          recover_base;
  phys_t [COMMIT_WIDTH-1:0]        recover_map;

  modport master (
    output commit, recover_flag,
    input  commit_ready, freed_valid, freed_reg, recover_busy, recover_valid,
           recover_base, recover_map
  );

  modport slave (
    input  commit, recover_flag,
    output commit_ready, freed_valid, freed_reg, recover_busy, recover_valid,
           recover_base, recover_map
  );
endinterface

// File: rtl/amt_regfile_4r4w.sv
// Flop array of logical->physical mappings; 4 combinational reads, 4 writes (higher slot wins).
// Reads are same-cycle, writes land on the next edge; no backpressure.
module amt_regfile_4r4w
  import arch_map_table_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  log_t  [COMMIT_WIDTH-1:0] raddr,
  output phys_t [COMMIT_WIDTH-1:0] rdata,
  input  logic  [COMMIT_WIDTH-1:0] we,
  input  log_t  [COMMIT_WIDTH-1:0] waddr,
  input  phys_t [COMMIT_WIDTH-1:0] wdata
);
  phys_t mem [SIZE_LOGICAL];

  // Ascending loop order makes the last (highest) slot's write win on a collision.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SIZE_LOGICAL; i++) mem[i] <= phys_t'(i);
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        if (we[k]) mem[waddr[k]] <= wdata[k];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < COMMIT_WIDTH; k++) rdata[k] = mem[raddr[k]];
  end
endmodule

// File: rtl/arch_map_table.sv
// Retire-side AMT: records committed mappings, frees displaced tags 1 cycle later, walks table on flush.
// Commits are refused (commit_ready=0) for the 8 walk cycles; freed outputs are never stalled.
module arch_map_table
  import arch_map_table_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  arch_map_table_if.slave bus
);
  typedef enum logic {IDLE, WALK} state_t;

  state_t                   state, state_nxt;
  group_t                   base, base_nxt;
  logic                     accept;
  log_t  [COMMIT_WIDTH-1:0] raddr;
  phys_t [COMMIT_WIDTH-1:0] rdata;
  logic  [COMMIT_WIDTH-1:0] we;
  log_t  [COMMIT_WIDTH-1:0] waddr;
  phys_t [COMMIT_WIDTH-1:0] wdata;
  phys_t [COMMIT_WIDTH-1:0] old_tag;
  logic  [COMMIT_WIDTH-1:0] freed_valid_q;
  phys_t [COMMIT_WIDTH-1:0] freed_reg_q;

  assign accept = (state == IDLE);

  amt_regfile_4r4w u_regfile (
    .clk   (clk),
    .reset (reset),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
  );

  // Read ports serve commit lookups when idle and the group walk otherwise.
  always_comb begin
    raddr   = '0;
    we      = '0;
    waddr   = '0;
    wdata   = '0;
    old_tag = '0;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      waddr[k] = bus.commit[k].log_dest;
      wdata[k] = bus.commit[k].phy_dest;
      we[k]    = accept & bus.commit[k].valid;
      raddr[k] = accept ? bus.commit[k].log_dest : {base, k[1:0]};
    end
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      old_tag[k] = rdata[k];
      for (int j = 0; j < COMMIT_WIDTH; j++) begin
        if (j < k && bus.commit[j].valid &&
            bus.commit[j].log_dest == bus.commit[k].log_dest)
          old_tag[k] = bus.commit[j].phy_dest;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    base_nxt  = base;
    case (state)
      IDLE: begin
        if (bus.recover_flag) begin
          state_nxt = WALK;
          base_nxt  = '0;
        end
      end
      WALK: begin
        if (bus.recover_flag) begin
          base_nxt = '0;
        end else if (base == group_t'(NUM_GROUPS - 1)) begin
          state_nxt = IDLE;
          base_nxt  = '0;
        end else begin
          base_nxt = base + group_t'(1);
        end
      end
      default: begin
        state_nxt = IDLE;
        base_nxt  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      base  <= '0;
    end else begin
      state <= state_nxt;
      base  <= base_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      freed_valid_q <= '0;
      freed_reg_q   <= '0;
    end else begin
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        freed_valid_q[k] <= we[k];
        freed_reg_q[k]   <= we[k] ? old_tag[k] : '0;
      end
    end
  end

  always_comb begin
    bus.commit_ready  = accept;
    bus.recover_busy  = !accept;
    bus.recover_valid = !accept;
    bus.recover_base  = accept ? '0 : base;
    bus.freed_valid   = freed_valid_q;
    bus.freed_reg     = freed_reg_q;
    for (int k = 0; k < COMMIT_WIDTH; k++) bus.recover_map[k] = accept ? '0 : rdata[k];
  end
endmodule

// File: tb/tb_arch_map_table.sv
// Scoreboard bench for arch_map_table: a per-register array model predicts freed tags and walk contents.
// Directed retire/flush/reset scenarios followed by randomized commits with occasional flushes.
module tb_arch_map_table;
  import arch_map_table_pkg::*;

  typedef struct packed {
    int                       cyc;
    logic [3:0]               mask;
    phys_t [COMMIT_WIDTH-1:0] regs;
  } freed_exp_t;

  typedef struct packed {
    int                       cyc;
    int                       base;
    phys_t [COMMIT_WIDTH-1:0] map;
  } walk_exp_t;

  typedef struct packed {
    int   cyc;
    logic ready;
    logic busy;
  } stat_exp_t;

  logic clk;
  logic reset;
  int   cycle;
  int   tests;
  int   fails;

  freed_exp_t fq[$];
  walk_exp_t  wq[$];
  stat_exp_t  sq[$];

  int m_amt [SIZE_LOGICAL];
  bit m_walk;
  int m_base;

  arch_map_table_if bus ();

  arch_map_table dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cycle <= cycle + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SIZE_LOGICAL; i++) m_amt[i] = i;
    m_walk = 1'b0;
    m_base = 0;
    fq.delete();
    wq.delete();
    sq.delete();
  endtask

  // One clock of stimulus; the model predicts this cycle's status/walk and next cycle's freed tags.
  task automatic step(input logic [3:0] v, input log_t [3:0] ld, input phys_t [3:0] pd,
                      input logic rf);
    stat_exp_t  se;
    walk_exp_t  we;
    freed_exp_t fe;
    @(posedge clk);
    #1;
    for (int k = 0; k < COMMIT_WIDTH; k++) begin
      bus.commit[k].valid    = v[k];
      bus.commit[k].log_dest = ld[k];
      bus.commit[k].phy_dest = pd[k];
    end
    bus.recover_flag = rf;
    se.cyc = cycle;
    se.ready = !m_walk;
    se.busy = m_walk;
    sq.push_back(se);
    if (m_walk) begin
      we.cyc = cycle;
      we.base = m_base;
      for (int k = 0; k < COMMIT_WIDTH; k++) we.map[k] = phys_t'(m_amt[4 * m_base + k]);
      wq.push_back(we);
    end else if (v != 4'b0) begin
      fe.cyc = cycle + 1;
      fe.mask = v;
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        fe.regs[k] = '0;
        if (v[k]) begin
          fe.regs[k] = phys_t'(m_amt[ld[k]]);
          m_amt[ld[k]] = int'(pd[k]);
        end
      end
      fq.push_back(fe);
    end
    if (rf) begin
      m_walk = 1'b1;
      m_base = 0;
    end else if (m_walk) begin
      if (m_base == NUM_GROUPS - 1) m_walk = 1'b0;
      else m_base++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(4'b0, '0, '0, 1'b0);
  endtask

  task automatic junk_step();
    step(4'($urandom), {log_t'($urandom), log_t'($urandom), log_t'($urandom), log_t'($urandom)},
         {phys_t'($urandom), phys_t'($urandom), phys_t'($urandom), phys_t'($urandom)}, 1'b0);
  endtask

  task automatic check_reset_outputs();
    chk("rst_freed_valid", int'(bus.freed_valid), 0);
    chk("rst_recover_valid", int'(bus.recover_valid), 0);
    chk("rst_recover_busy", int'(bus.recover_busy), 0);
    chk("rst_commit_ready", int'(bus.commit_ready), 1);
  endtask

  // Monitor: pops whatever the scoreboard expects for this cycle and flags anything unexpected.
  freed_exp_t mfe;
  walk_exp_t  mwe;
  stat_exp_t  mse;
  always @(negedge clk) begin
    if (reset) begin
      while (fq.size() > 0 && fq[0].cyc < cycle) begin
        tests++; fails++;
        $display("FAIL freed_missing: expected cycle %0d never checked", fq[0].cyc);
        void'(fq.pop_front());
      end
      if (fq.size() > 0 && fq[0].cyc == cycle) begin
        mfe = fq.pop_front();
        chk("freed_valid", int'(bus.freed_valid), int'(mfe.mask));
        for (int k = 0; k < COMMIT_WIDTH; k++)
          if (mfe.mask[k]) chk($sformatf("freed_reg%0d", k), int'(bus.freed_reg[k]), int'(mfe.regs[k]));
      end else if (bus.freed_valid != 4'b0) begin
        chk("freed_spurious", int'(bus.freed_valid), 0);
      end

      while (wq.size() > 0 && wq[0].cyc < cycle) void'(wq.pop_front());
      if (wq.size() > 0 && wq[0].cyc == cycle) begin
        mwe = wq.pop_front();
        chk("recover_valid", int'(bus.recover_valid), 1);
        chk("recover_base", int'(bus.recover_base), mwe.base);
        for (int k = 0; k < COMMIT_WIDTH; k++)
          chk($sformatf("recover_map%0d", k), int'(bus.recover_map[k]), int'(mwe.map[k]));
      end else if (bus.recover_valid) begin
        chk("recover_spurious", int'(bus.recover_valid), 0);
      end

      while (sq.size() > 0 && sq[0].cyc < cycle) void'(sq.pop_front());
      if (sq.size() > 0 && sq[0].cyc == cycle) begin
        mse = sq.pop_front();
        chk("commit_ready", int'(bus.commit_ready), int'(mse.ready));
        chk("recover_busy", int'(bus.recover_busy), int'(mse.busy));
      end
    end
  end

  initial begin
    tests = 0;
    fails = 0;
    cycle = 0;
    reset = 1'b0;
    bus.commit = '0;
    bus.recover_flag = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_reset_outputs();
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Identity after reset, seen through a full walk.
    step(4'b0, '0, '0, 1'b1);
    idle(9);

    // r5 -> p40 frees 5, then r5 -> p41 frees 40.
    step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {7'd0, 7'd0, 7'd0, 7'd40}, 1'b0);
    idle(1);
    step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd5}, {7'd0, 7'd0, 7'd0, 7'd41}, 1'b0);
    idle(1);

    // r7 in slots 0,1,3 in one cycle: intra-group bypass and last-writer-wins.
    step(4'b1011, {5'd7, 5'd9, 5'd7, 5'd7}, {7'd52, 7'd99, 7'd51, 7'd50}, 1'b0);
    // Sparse valid pattern to r1 / r2.
    step(4'b1010, {5'd2, 5'd0, 5'd1, 5'd0}, {7'd70, 7'd0, 7'd71, 7'd0}, 1'b0);
    idle(1);

    // Flush in the same cycle as r3 -> p60; commits during the walk must be ignored.
    step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd3}, {7'd0, 7'd0, 7'd0, 7'd60}, 1'b1);
    for (int i = 0; i < 8; i++) junk_step();
    idle(2);

    // Flush again at walk cycle 4 restarts at base 0.
    step(4'b0, '0, '0, 1'b1);
    for (int i = 0; i < 4; i++) junk_step();
    step(4'b0, '0, '0, 1'b1);
    idle(10);

    // Reset during walk cycle 2.
    step(4'b0001, {5'd0, 5'd0, 5'd0, 5'd12}, {7'd0, 7'd0, 7'd0, 7'd100}, 1'b1);
    idle(2);
    @(posedge clk);
    #1;
    bus.commit = '0;
    bus.recover_flag = 1'b0;
    reset = 1'b0;
    #1;
    check_reset_outputs();
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(4'b0, '0, '0, 1'b1);
    idle(9);

    // Randomized commits, collision-biased, with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      logic  [3:0] v;
      log_t  [3:0] ld;
      phys_t [3:0] pd;
      v = 4'($urandom);
      for (int k = 0; k < COMMIT_WIDTH; k++) begin
        ld[k] = ($urandom_range(0, 1) == 0) ? log_t'($urandom_range(0, 3)) : log_t'($urandom);
        pd[k] = phys_t'($urandom);
      end
      step(v, ld, pd, ($urandom_range(0, 24) == 0));
    end
    idle(12);
    step(4'b0, '0, '0, 1'b1);
    idle(10);

    tests++;
    if (fq.size() != 0 || wq.size() != 0) begin
      fails++;
      $display("FAIL queues_drained: freed left %0d, walk left %0d, expected 0", fq.size(), wq.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
